// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one outstanding word read at a
// time, and buffers returned instructions in a small FIFO for the control unit.
// A redirect flushes the buffer; a read already in flight is drained and its
// data thrown away.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        inst_consume_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        inst_ready_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fq_entry_t;

  fq_entry_t       fq [FIFO_DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count, count_next;
  logic [1:0]      state;
  logic [31:0]     fetch_pc, pc_inc, redir_pc;
  logic            push, pop, credit;
  logic            unused_redir_lo;

  // Low address bits of a redirect target are dropped (word aligned fetch).
  assign unused_redir_lo = ^redirect_pc_i[1:0];
  assign redir_pc        = {redirect_pc_i[31:2], 2'b00};
  assign pc_inc          = fetch_pc + 32'd4;

  // Redirect wins over push/pop; the FIFO is simply cleared that cycle.
  assign push       = (state == S_WAIT) && mem_ack_i && !redirect_i;
  assign pop        = inst_ready_o && inst_consume_i && !redirect_i;
  assign count_next = count + CW'(push) - CW'(pop);
  assign credit     = count_next < CW'(FIFO_DEPTH);

  // Head of the FIFO, forced to zero when empty.
  assign inst_ready_o = (count != '0);
  assign inst_o       = inst_ready_o ? fq[rd_ptr].inst : 32'h0;
  assign inst_pc_o    = inst_ready_o ? fq[rd_ptr].pc   : 32'h0;

  // FIFO storage write; contents are don't-care while not counted.
  always_ff @(posedge clk_i) begin
    if (push) fq[wr_ptr] <= '{inst: mem_data_i, pc: mem_addr_o};
  end

  // Fetch FSM, PC and FIFO bookkeeping.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state      <= S_IDLE;
      fetch_pc   <= RESET_PC;
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      mem_req_o  <= 1'b0;
      mem_addr_o <= 32'h0;
    end else if (redirect_i) begin
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fetch_pc <= redir_pc;
      case (state)
        S_WAIT, S_DRAIN: begin
          // A pending read must still complete before a new one is issued.
          if (mem_ack_i) begin
            state     <= S_IDLE;
            mem_req_o <= 1'b0;
          end else begin
            state <= S_DRAIN;
          end
        end
        default: begin
          state     <= S_IDLE;
          mem_req_o <= 1'b0;
        end
      endcase
    end else begin
      count <= count_next;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case (state)
        S_IDLE: begin
          if (credit) begin
            state      <= S_WAIT;
            mem_req_o  <= 1'b1;
            mem_addr_o <= fetch_pc;
          end
        end
        S_WAIT: begin
          if (mem_ack_i) begin
            fetch_pc <= pc_inc;
            // Back-to-back request when the buffer still has room.
            if (credit) begin
              mem_addr_o <= pc_inc;
            end else begin
              state     <= S_IDLE;
              mem_req_o <= 1'b0;
            end
          end
        end
        S_DRAIN: begin
          if (mem_ack_i) begin
            state     <= S_IDLE;
            mem_req_o <= 1'b0;
          end
        end
        default: begin
          state     <= S_IDLE;
          mem_req_o <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a behavioural memory acks requests after a
// programmable latency, expected {inst, pc} pairs are queued at each ack and
// compared when the consumer pops the head.
module tb_fetch_unit;
  logic        clk_i = 1'b0;
  logic        reset_i, inst_consume_i, redirect_i, mem_ack_i;
  logic [31:0] redirect_pc_i, mem_data_i;
  logic [31:0] inst_o, inst_pc_o, mem_addr_o;
  logic        inst_ready_o, mem_req_o;

  fetch_unit #(.RESET_PC(32'h100), .FIFO_DEPTH(2)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .inst_consume_i(inst_consume_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
    .inst_o(inst_o), .inst_pc_o(inst_pc_o), .inst_ready_o(inst_ready_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [31:0] inst; logic [31:0] pc; } exp_t;
  exp_t        sb[$];
  int          n_chk = 0, n_pass = 0;
  logic [31:0] exp_pc, drain_addr;
  int          wait_cnt, pushes, pops;
  bit          drain;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  // Reset pulse, reset-value checks, then restart from RESET_PC.
  task automatic do_reset();
    reset_i = 1'b1; inst_consume_i = 1'b0; redirect_i = 1'b0;
    redirect_pc_i = 32'h0; mem_ack_i = 1'b0; mem_data_i = 32'h0;
    tick();
    chk("rst_req",   {31'h0, mem_req_o},    32'h0);
    chk("rst_addr",  mem_addr_o,            32'h0);
    chk("rst_ready", {31'h0, inst_ready_o}, 32'h0);
    chk("rst_inst",  inst_o,                32'h0);
    chk("rst_pc",    inst_pc_o,             32'h0);
    reset_i = 1'b0;
    tick();
    chk("e1_req",  {31'h0, mem_req_o}, 32'h1);
    chk("e1_addr", mem_addr_o,         32'h100);
    sb.delete(); exp_pc = 32'h100; wait_cnt = 0; drain = 0; pushes = 0; pops = 0;
  endtask

  // One cycle: consumer side checks against the scoreboard, memory side acks
  // after `lat` cycles of a visible request and queues the expectation.
  task automatic cycle(input int lat, input bit consume);
    exp_t e;
    inst_consume_i = consume;
    if (consume && inst_ready_o) begin
      if (sb.size() == 0) chk("sb_underflow", 32'(sb.size()), 32'd1);
      else begin
        e = sb.pop_front();
        chk("head_inst", inst_o,    e.inst);
        chk("head_pc",   inst_pc_o, e.pc);
      end
      pops++;
    end
    mem_ack_i = 1'b0; mem_data_i = 32'h0;
    if (mem_req_o) begin
      if (wait_cnt >= lat) begin
        mem_ack_i  = 1'b1;
        mem_data_i = mem_addr_o ^ 32'hA5A5_0000;
        if (drain) begin
          chk("drain_addr", mem_addr_o, drain_addr);
          drain = 0;
        end else begin
          chk("req_addr", mem_addr_o, exp_pc);
          sb.push_back('{inst: exp_pc ^ 32'hA5A5_0000, pc: exp_pc});
          exp_pc = exp_pc + 32'd4;
          pushes++;
        end
        wait_cnt = 0;
      end else wait_cnt++;
    end else wait_cnt = 0;
    tick();
    inst_consume_i = 1'b0; mem_ack_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();

    // In-order stream, memory acks one cycle after each request.
    for (int i = 0; i < 14; i++) cycle(1, 1'b1);
    chk("stream_pops", 32'(pops >= 4), 32'h1);

    // Stalled consumer: two pushes then the request drops.
    do_reset();
    for (int i = 0; i < 6; i++) cycle(0, 1'b0);
    chk("stall_pushes", 32'(pushes),         32'd2);
    chk("stall_req",    {31'h0, mem_req_o},  32'h0);
    chk("stall_ready",  {31'h0, inst_ready_o}, 32'h1);
    cycle(0, 1'b1);
    chk("refill_req",  {31'h0, mem_req_o}, 32'h1);
    chk("refill_addr", mem_addr_o,         32'h108);
    for (int i = 0; i < 4; i++) cycle(0, 1'b0);
    chk("refill_pushes", 32'(pushes), 32'd3);
    chk("refill_req_off", {31'h0, mem_req_o}, 32'h0);

    // Zero-wait memory with continuous consume: one instruction per cycle.
    do_reset();
    for (int i = 0; i < 4; i++) cycle(0, 1'b1);
    pops = 0;
    for (int i = 0; i < 16; i++) cycle(0, 1'b1);
    chk("tput_pops", 32'(pops), 32'd16);

    // Redirect while the read for 0x10C is pending, stale ack delayed.
    do_reset();
    for (int i = 0; i < 10 && exp_pc != 32'h10C; i++) cycle(0, 1'b1);
    chk("pend_addr", mem_addr_o, 32'h10C);
    redirect_i = 1'b1; redirect_pc_i = 32'h2002;
    tick();
    redirect_i = 1'b0;
    chk("redir_ready", {31'h0, inst_ready_o}, 32'h0);
    chk("redir_inst",  inst_o,                32'h0);
    chk("redir_req",   {31'h0, mem_req_o},    32'h1);
    chk("redir_hold",  mem_addr_o,            32'h10C);
    sb.delete(); exp_pc = 32'h2000; drain = 1; drain_addr = 32'h10C;
    wait_cnt = 1; pops = 0;
    for (int i = 0; i < 20; i++) cycle(3, 1'b1);
    chk("redir_drained", {31'h0, drain},  32'h0);
    chk("redir_pops",    32'(pops >= 2),  32'h1);

    // Redirect, pop and ack together with one buffered entry.
    do_reset();
    cycle(0, 1'b0);
    chk("one_entry", {31'h0, inst_ready_o}, 32'h1);
    redirect_i = 1'b1; redirect_pc_i = 32'h3000; inst_consume_i = 1'b1;
    mem_ack_i = 1'b1; mem_data_i = 32'hDEAD_BEEF;
    tick();
    redirect_i = 1'b0; inst_consume_i = 1'b0; mem_ack_i = 1'b0;
    chk("rpa_ready", {31'h0, inst_ready_o}, 32'h0);
    chk("rpa_inst",  inst_o,                32'h0);
    chk("rpa_req",   {31'h0, mem_req_o},    32'h0);
    tick();
    chk("rpa_newreq",  {31'h0, mem_req_o}, 32'h1);
    chk("rpa_newaddr", mem_addr_o,         32'h3000);

    // Reset while a request is outstanding.
    do_reset();

    // Redirect near the top of memory: PC wraps to zero.
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFE;
    tick();
    redirect_i = 1'b0;
    sb.delete(); exp_pc = 32'hFFFF_FFFC; drain = 1; drain_addr = 32'h100;
    wait_cnt = 1; pops = 0;
    for (int i = 0; i < 10; i++) cycle(0, 1'b1);
    chk("wrap_pops", 32'(pops >= 3), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
